// File: rtl/serdes_pkg.sv
// serdes_pkg: alignment FSM state encodings and link defaults shared by serializer and deserializer.
`default_nettype none

package serdes_pkg;

  localparam int unsigned      DEF_WIDTH      = 32;
  localparam logic [31:0]      DEF_SYNC_WORD  = 32'h5A5A_C33C;
  localparam int unsigned      DEF_LOCK_COUNT = 2;
  localparam int unsigned      DEF_LOL_WORDS  = 16;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/deserializer_aligner_sync_word_detector.sv
// sync_word_detector: LSB-first shift window, primed flag and SYNC_WORD comparator.
`default_nettype none

module sync_word_detector
  import serdes_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DEF_SYNC_WORD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_bit,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_sr,
  output logic             o_match
);

  localparam int unsigned PCNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]  r_sr;
  logic [PCNT_W-1:0] r_pcnt;
  logic              r_primed;

  // The window shifts on every edge, including the one that clears priming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr     <= '0;
      r_pcnt   <= '0;
      r_primed <= 1'b0;
    end else begin
      r_sr <= {i_bit, r_sr[WIDTH-1:1]};
      if (i_clear) begin
        r_pcnt   <= '0;
        r_primed <= 1'b0;
      end else if (!r_primed) begin
        r_pcnt   <= r_pcnt + 1'b1;
        r_primed <= (r_pcnt == PCNT_W'(WIDTH-1));
      end
    end
  end

  assign o_sr    = r_sr;
  assign o_match = r_primed && (r_sr == SYNC_WORD);

endmodule

`default_nettype wire

// File: rtl/deserializer_aligner.sv
// deserializer_aligner: hunts SYNC_WORD in an LSB-first bit stream, locks, and strobes out aligned words.
// DESERIALIZER_ALIGNER_LOL_EN enables the loss-of-lock miss counter (LOL_WORDS).
`default_nettype none

module deserializer_aligner
  import serdes_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(DEF_SYNC_WORD),
  parameter int unsigned      LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned      LOL_WORDS  = DEF_LOL_WORDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             I,
  input  logic             resync,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  output logic             O_sync,
  output logic             locked
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

  if (WIDTH < 4 || LOCK_COUNT < 1 || LOL_WORDS < 1) begin : g_param_chk
    $error("deserializer_aligner: illegal WIDTH/LOCK_COUNT/LOL_WORDS");
  end

  logic [WIDTH-1:0]  w_sr;
  logic              w_match;

  state_t            r_state,  w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
  logic [GOOD_W-1:0] r_good,   w_good_nxt;
  logic [WIDTH-1:0]  r_o,      w_o_nxt;
  logic              r_valid,  w_valid_nxt;
  logic              r_osync,  w_osync_nxt;
  logic              r_bnd;
  logic              r_locked;

`ifdef DESERIALIZER_ALIGNER_LOL_EN
  localparam int unsigned MISS_W = $clog2(LOL_WORDS + 1);
  logic [MISS_W-1:0] r_miss, w_miss_nxt;
`endif

  sync_word_detector #(
    .WIDTH     (WIDTH),
    .SYNC_WORD (SYNC_WORD)
  ) u_detector (
    .clk     (clk),
    .reset   (reset),
    .i_bit   (I),
    .i_clear (resync),
    .o_sr    (w_sr),
    .o_match (w_match)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == CNT_W'(WIDTH-1)) ? '0 : r_cnt + 1'b1;
    w_good_nxt  = r_good;
    w_o_nxt     = r_o;
    w_valid_nxt = 1'b0;
    w_osync_nxt = r_osync;
`ifdef DESERIALIZER_ALIGNER_LOL_EN
    w_miss_nxt  = r_miss;
`endif
    if (resync) begin
      w_state_nxt = ST_HUNT;
      w_cnt_nxt   = '0;
      w_good_nxt  = '0;
`ifdef DESERIALIZER_ALIGNER_LOL_EN
      w_miss_nxt  = '0;
`endif
    end else begin
      case (r_state)
        ST_HUNT: begin
          // The bit arriving on this edge is bit 0 of the word after the sync word.
          if (w_match) begin
            w_cnt_nxt   = '0;
            w_good_nxt  = GOOD_W'(1);
            w_state_nxt = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (r_bnd) begin
            if (w_match) begin
              w_good_nxt = r_good + 1'b1;
              if (r_good >= GOOD_W'(LOCK_COUNT-1)) begin
                w_state_nxt = ST_LOCKED;
              end
            end else begin
              w_good_nxt  = '0;
              w_state_nxt = ST_HUNT;
            end
          end
        end
        ST_LOCKED: begin
          if (r_bnd) begin
            w_o_nxt     = w_sr;
            w_valid_nxt = 1'b1;
            w_osync_nxt = w_match;
`ifdef DESERIALIZER_ALIGNER_LOL_EN
            if (w_match) begin
              w_miss_nxt = '0;
            end else if (r_miss == MISS_W'(LOL_WORDS-1)) begin
              w_miss_nxt  = '0;
              w_good_nxt  = '0;
              w_state_nxt = ST_HUNT;
            end else begin
              w_miss_nxt = r_miss + 1'b1;
            end
`endif
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_good_nxt  = '0;
        end
      endcase
    end
  end

  // r_bnd is registered from the next count so that it is high exactly while the window holds a full word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_HUNT;
      r_cnt    <= '0;
      r_bnd    <= 1'b0;
      r_good   <= '0;
      r_o      <= '0;
      r_valid  <= 1'b0;
      r_osync  <= 1'b0;
      r_locked <= 1'b0;
`ifdef DESERIALIZER_ALIGNER_LOL_EN
      r_miss   <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bnd    <= (w_cnt_nxt == CNT_W'(WIDTH-1));
      r_good   <= w_good_nxt;
      r_o      <= w_o_nxt;
      r_valid  <= w_valid_nxt;
      r_osync  <= w_osync_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
`ifdef DESERIALIZER_ALIGNER_LOL_EN
      r_miss   <= w_miss_nxt;
`endif
    end
  end

  assign O       = r_o;
  assign O_valid = r_valid;
  assign O_sync  = r_osync;
  assign locked  = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_deserializer_aligner.sv
// tb_deserializer_aligner: scoreboard bench for deserializer_aligner (WIDTH=8, SYNC_WORD=A5, LOCK_COUNT=2, LOL_WORDS=3).
`default_nettype none

module tb_deserializer_aligner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       I = 1'b0;
  logic       resync = 1'b0;
  logic [7:0] O;
  logic       O_valid;
  logic       O_sync;
  logic       locked;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_strobes = 0;
  int last_strobe = 0;
  int prev_strobe = 0;

  logic [8:0] sb[$];

  deserializer_aligner #(
    .WIDTH      (8),
    .SYNC_WORD  (8'hA5),
    .LOCK_COUNT (2),
    .LOL_WORDS  (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .I       (I),
    .resync  (resync),
    .O       (O),
    .O_valid (O_valid),
    .O_sync  (O_sync),
    .locked  (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest word expected.
  always @(negedge clk) begin
    if (!reset && O_valid) begin
      n_strobes++;
      prev_strobe = last_strobe;
      last_strobe = cyc;
      if (sb.size() == 0) begin
        chk("sb_unexpected_strobe", 32'(sb.size()), 32'd1);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("O", {24'd0, O}, {24'd0, e[7:0]});
        chk("O_sync", {31'd0, O_sync}, {31'd0, e[8]});
      end
    end
  end

  task automatic send_bit(input logic b);
    I = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [7:0] w, input logic expect_out);
    if (expect_out) sb.push_back({(w == 8'hA5), w});
    send_bits(w, 8);
  endtask

  task automatic push_exp(input logic [7:0] w, input logic s);
    sb.push_back({s, w});
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    resync = 1'b0;
    I      = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_O", {24'd0, O}, 32'd0);
    chk("rst_O_valid", {31'd0, O_valid}, 32'd0);
    chk("rst_O_sync", {31'd0, O_sync}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
  endtask

  task automatic drain(input string tag);
    send_bits(8'h00, 2);
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int s0;
    logic x;

    // 1: basic lock and delivery
    do_reset();
    send_word(8'hA5, 1'b0);
    send_word(8'hA5, 1'b0);
    chk("t1_locked_early", {31'd0, locked}, 32'd0);
    send_word(8'h3C, 1'b1);
    chk("t1_locked", {31'd0, locked}, 32'd1);
    send_word(8'hA5, 1'b1);
    drain("t1_sb_empty");
    chk("t1_strobe_gap", 32'(last_strobe - prev_strobe), 32'd8);
    chk("t1_O_hold", {24'd0, O}, 32'h0000_00A5);

    // 2: idle zeros never lock
    do_reset();
    s0 = n_strobes;
    send_bits(8'h00, 8);
    send_bits(8'h00, 8);
    send_bits(8'h00, 4);
    @(negedge clk);
    chk("t2_locked", {31'd0, locked}, 32'd0);
    chk("t2_strobes", 32'(n_strobes - s0), 32'd0);
    chk("t2_O", {24'd0, O}, 32'd0);

    // 3: verify failure returns to hunt, then re-lock
    do_reset();
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    chk("t3_locked_after_miss", {31'd0, locked}, 32'd0);
    send_word(8'hA5, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b1);
    chk("t3_relocked", {31'd0, locked}, 32'd1);
    drain("t3_sb_empty");

    // 4: one extra bit slips the boundary
    do_reset();
    send_word(8'hA5, 1'b0);
    send_word(8'hA5, 1'b0);
    x = 1'($urandom_range(0, 1));
    push_exp(8'h78 | {7'd0, x}, 1'b0);
    push_exp(8'h78, 1'b0);
    push_exp(8'h78, 1'b0);
    send_bit(x);
    send_word(8'h3C, 1'b0);
    send_word(8'h3C, 1'b0);
    send_word(8'h3C, 1'b0);
    @(negedge clk);
`ifdef DESERIALIZER_ALIGNER_LOL_EN
    chk("t4_lol_locked", {31'd0, locked}, 32'd0);
    drain("t4_sb_empty_lol");
    send_word(8'hA5, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b1);
    chk("t4_relocked", {31'd0, locked}, 32'd1);
    drain("t4_sb_empty_relock");
`else
    chk("t4_still_locked", {31'd0, locked}, 32'd1);
    drain("t4_sb_empty");
`endif

    // 5: resync mid-word
    do_reset();
    send_word(8'hA5, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b1);
    send_bits(8'hA5, 4);
    resync = 1'b1;
    send_bit(1'b0);
    resync = 1'b0;
    @(negedge clk);
    chk("t5_locked", {31'd0, locked}, 32'd0);
    chk("t5_O_valid", {31'd0, O_valid}, 32'd0);
    chk("t5_O_kept", {24'd0, O}, 32'h0000_003C);
    send_bits(8'h05, 3);
    send_word(8'hA5, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b1);
    chk("t5_relocked", {31'd0, locked}, 32'd1);
    drain("t5_sb_empty");

    // 6: asynchronous reset mid-word
    do_reset();
    send_word(8'hA5, 1'b0);
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b1);
    send_bits(8'h5A, 4);
    chk("t6_pre_locked", {31'd0, locked}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_O", {24'd0, O}, 32'd0);
    chk("t6_O_valid", {31'd0, O_valid}, 32'd0);
    chk("t6_locked", {31'd0, locked}, 32'd0);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    s0 = n_strobes;
    send_bits(8'h5A, 4);
    send_bits(8'h3C, 8);
    @(negedge clk);
    chk("t6_no_partial", 32'(n_strobes - s0), 32'd0);
    chk("t6_locked_after", {31'd0, locked}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
